rd_ctrl: RTL and testbench

Read-side counterpart of the write packer. It issues AXI read-burst requests to the DDR buffer, then unpacks each returned AXI_DATA_WIDTH beat into USER_DATA_WIDTH words for the user read port. Two modes are supported:
- Ring mode (user_rd_mode=0): streams the same base..end ring the writer fills, throttled by a count of completed write bursts.
- Single-shot mode (user_rd_mode=1): performs one user-addressed read of user_rd_length bytes.

---
 rtl/rd_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_rd_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_ctrl.sv
// Read-side controller: issues AXI read bursts (ring or single-shot) and unpacks
// each returned beat into user-width words, lowest slice first.
module rd_ctrl #(
  parameter int USER_DATA_WIDTH = 16,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int AXI_BURST_LEN   = 4096
) (
  input  logic                       clk,
  input  logic                       resetn_sync,
  input  logic                       ddr_init_done,
  input  logic                       user_rd_mode,
  input  logic                       user_rd_req,
  input  logic [AXI_ADDR_WIDTH-1:0]  user_rd_addr,
  input  logic [12:0]                user_rd_length,
  input  logic [AXI_ADDR_WIDTH-1:0]  user_base_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]  user_end_addr,
  input  logic                       wr_burst_done,
  input  logic                       user_rd_ready,
  output logic [USER_DATA_WIDTH-1:0] user_rd_data,
  output logic                       user_rd_valid,
  output logic                       user_rd_last,
  output logic                       rd_req_en,
  output logic [AXI_ADDR_WIDTH-1:0]  rd_addr_out,
  output logic [7:0]                 rd_burst_len,
  input  logic [AXI_DATA_WIDTH-1:0]  rd_data_in,
  input  logic                       rd_data_valid,
  input  logic                       rd_data_last,
  output logic                       rd_data_ready,
  output logic                       rd_busy
);

  localparam int BEAT_BYTES    = AXI_DATA_WIDTH / 8;
  localparam int BEAT_SHIFT    = $clog2(BEAT_BYTES);
  localparam int MAX_RD_CNT    = AXI_DATA_WIDTH / USER_DATA_WIDTH;
  localparam int AXI_BURST_CNT = AXI_BURST_LEN / BEAT_BYTES;
  localparam int CW            = (MAX_RD_CNT > 1) ? $clog2(MAX_RD_CNT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                sync_q, sync_d;
  logic                      init_seen_q, init_seen_d;
  logic                      mode_q, mode_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [12:0]               len_q, len_d;
  logic [AXI_ADDR_WIDTH-1:0] ring_ptr_q, ring_ptr_d;
  logic [7:0]                avail_cnt_q, avail_cnt_d;
  logic                      rd_req_en_q, rd_req_en_d;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_out_q, rd_addr_out_d;
  logic [7:0]                rd_burst_len_q, rd_burst_len_d;
  logic [AXI_DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]             slice_q, slice_d;
  logic                      full_q, full_d;
  logic                      beat_last_q, beat_last_d;
  logic                      last_q, last_d;

  logic ddr_init_done_en;
  logic hs;
  logic last_slice;
  logic accept;
  logic avail_inc;
  logic avail_dec;

  assign ddr_init_done_en = sync_q[2];
  assign hs               = full_q & user_rd_ready;
  assign last_slice       = (slice_q == CW'(MAX_RD_CNT - 1));
  assign accept           = rd_data_valid & rd_data_ready;
  assign avail_inc        = wr_burst_done;
  assign avail_dec        = rd_req_en_q & ~mode_q;

  // Request FSM, ring pointer, write-burst credit counter and init synchronizer
  always_comb begin
    state_d        = state_q;
    sync_d         = {sync_q[1:0], ddr_init_done};
    init_seen_d    = init_seen_q;
    mode_d         = mode_q;
    addr_d         = addr_q;
    len_d          = len_q;
    ring_ptr_d     = ring_ptr_q;
    avail_cnt_d    = avail_cnt_q;
    rd_req_en_d    = 1'b0;
    rd_addr_out_d  = rd_addr_out_q;
    rd_burst_len_d = rd_burst_len_q;

    if (ddr_init_done_en && !init_seen_q) begin
      init_seen_d = 1'b1;
      ring_ptr_d  = user_base_addr;
    end else begin
      init_seen_d = init_seen_q;
    end

    if (avail_inc && !avail_dec && avail_cnt_q != 8'd255) begin
      avail_cnt_d = avail_cnt_q + 8'd1;
    end else if (avail_dec && !avail_inc && avail_cnt_q != 8'd0) begin
      avail_cnt_d = avail_cnt_q - 8'd1;
    end else begin
      avail_cnt_d = avail_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (init_seen_q && ddr_init_done_en) begin
          if (user_rd_mode) begin
            if (user_rd_req) begin
              mode_d  = 1'b1;
              addr_d  = user_rd_addr;
              len_d   = user_rd_length;
              state_d = REQ;
            end else begin
              state_d = IDLE;
            end
          end else if (avail_cnt_q != 8'd0) begin
            mode_d  = 1'b0;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        rd_req_en_d = 1'b1;
        if (mode_q) begin
          rd_addr_out_d  = addr_q;
          rd_burst_len_d = 8'((len_q >> BEAT_SHIFT) - 13'd1);
        end else begin
          rd_addr_out_d  = ring_ptr_q;
          rd_burst_len_d = 8'(AXI_BURST_CNT - 1);
          if (ring_ptr_q >= (user_end_addr - AXI_ADDR_WIDTH'(AXI_BURST_LEN))) begin
            ring_ptr_d = user_base_addr;
          end else begin
            ring_ptr_d = ring_ptr_q + AXI_ADDR_WIDTH'(AXI_BURST_LEN);
          end
        end
        state_d = DATA;
      end
      DATA: begin
        if (hs && last_q) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Beat unpacker; a new beat may load on the same edge the last slice leaves
  always_comb begin
    sh_d          = sh_q;
    slice_d       = slice_q;
    full_d        = full_q;
    beat_last_d   = beat_last_q;
    last_d        = last_q;
    rd_data_ready = 1'b0;

    if (state_q == DATA) begin
      rd_data_ready = ~full_q | (hs & last_slice & ~beat_last_q);
    end else begin
      rd_data_ready = 1'b0;
    end

    if (accept) begin
      sh_d        = rd_data_in;
      slice_d     = '0;
      full_d      = 1'b1;
      beat_last_d = rd_data_last;
      last_d      = rd_data_last & (MAX_RD_CNT == 1);
    end else if (hs) begin
      if (last_slice) begin
        full_d = 1'b0;
        last_d = 1'b0;
      end else begin
        sh_d    = sh_q >> USER_DATA_WIDTH;
        slice_d = slice_q + CW'(1);
        last_d  = beat_last_q & ((slice_q + CW'(1)) == CW'(MAX_RD_CNT - 1));
      end
    end else begin
      sh_d = sh_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn_sync) begin
    if (!resetn_sync) begin
      state_q        <= IDLE;
      sync_q         <= 3'b000;
      init_seen_q    <= 1'b0;
      mode_q         <= 1'b0;
      addr_q         <= '0;
      len_q          <= 13'd0;
      ring_ptr_q     <= '0;
      avail_cnt_q    <= 8'd0;
      rd_req_en_q    <= 1'b0;
      rd_addr_out_q  <= '0;
      rd_burst_len_q <= 8'd0;
      sh_q           <= '0;
      slice_q        <= '0;
      full_q         <= 1'b0;
      beat_last_q    <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      init_seen_q    <= init_seen_d;
      mode_q         <= mode_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      ring_ptr_q     <= ring_ptr_d;
      avail_cnt_q    <= avail_cnt_d;
      rd_req_en_q    <= rd_req_en_d;
      rd_addr_out_q  <= rd_addr_out_d;
      rd_burst_len_q <= rd_burst_len_d;
      sh_q           <= sh_d;
      slice_q        <= slice_d;
      full_q         <= full_d;
      beat_last_q    <= beat_last_d;
      last_q         <= last_d;
    end
  end

  assign user_rd_data  = sh_q[USER_DATA_WIDTH-1:0];
  assign user_rd_valid = full_q;
  assign user_rd_last  = last_q;
  assign rd_req_en     = rd_req_en_q;
  assign rd_addr_out   = rd_addr_out_q;
  assign rd_burst_len  = rd_burst_len_q;
  assign rd_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rd_ctrl.sv
// Directed bench for rd_ctrl: a DDR-side responder returns incrementing words,
// a user-side monitor checks word order, last placement and ready discipline.
module tb_rd_ctrl;
  localparam int UW = 16;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int BL = 4096;
  localparam int WPB = DW / UW;

  logic          clk = 1'b0;
  logic          resetn_sync;
  logic          ddr_init_done;
  logic          user_rd_mode;
  logic          user_rd_req;
  logic [AW-1:0] user_rd_addr;
  logic [12:0]   user_rd_length;
  logic [AW-1:0] user_base_addr;
  logic [AW-1:0] user_end_addr;
  logic          wr_burst_done;
  logic          user_rd_ready;
  logic [UW-1:0] user_rd_data;
  logic          user_rd_valid;
  logic          user_rd_last;
  logic          rd_req_en;
  logic [AW-1:0] rd_addr_out;
  logic [7:0]    rd_burst_len;
  logic [DW-1:0] rd_data_in;
  logic          rd_data_valid;
  logic          rd_data_last;
  logic          rd_data_ready;
  logic          rd_busy;

  always #5 clk = ~clk;

  rd_ctrl #(.USER_DATA_WIDTH(UW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_BURST_LEN(BL)) dut (
    .clk(clk), .resetn_sync(resetn_sync), .ddr_init_done(ddr_init_done),
    .user_rd_mode(user_rd_mode), .user_rd_req(user_rd_req), .user_rd_addr(user_rd_addr),
    .user_rd_length(user_rd_length), .user_base_addr(user_base_addr), .user_end_addr(user_end_addr),
    .wr_burst_done(wr_burst_done), .user_rd_ready(user_rd_ready), .user_rd_data(user_rd_data),
    .user_rd_valid(user_rd_valid), .user_rd_last(user_rd_last), .rd_req_en(rd_req_en),
    .rd_addr_out(rd_addr_out), .rd_burst_len(rd_burst_len), .rd_data_in(rd_data_in),
    .rd_data_valid(rd_data_valid), .rd_data_last(rd_data_last), .rd_data_ready(rd_data_ready),
    .rd_busy(rd_busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int req_cnt = 0;
  logic [AW-1:0] req_addr [0:31];
  logic [7:0]    req_len  [0:31];
  int mon_words = 0, mon_bad = 0, mon_lasts = 0, mon_last_bad = 0, mon_gap = 0, mon_rdy_bad = 0;
  logic [15:0] seed = 16'h0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_lasts(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (mon_lasts < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, mon_lasts, target);
  endtask

  // DDR responder: records each request and returns its beats, data = seed + word index
  initial begin
    int  r_left, r_idx, r_pend_len;
    bit  r_pend, acc;
    r_left = 0; r_idx = 0; r_pend = 1'b0; r_pend_len = 0;
    rd_data_valid = 1'b0; rd_data_last = 1'b0; rd_data_in = '0;
    forever begin
      @(negedge clk);
      #2;
      acc = rd_data_valid && rd_data_ready;
      if (rd_req_en) begin
        req_addr[req_cnt % 32] = rd_addr_out;
        req_len[req_cnt % 32]  = rd_burst_len;
        req_cnt++;
        r_pend     = 1'b1;
        r_pend_len = int'(rd_burst_len) + 1;
      end
      @(posedge clk);
      #1;
      if (!resetn_sync) begin
        r_left = 0;
        r_pend = 1'b0;
      end else begin
        if (acc) begin
          r_left--;
          r_idx++;
        end
        if (r_left == 0 && r_pend) begin
          r_left = r_pend_len;
          r_idx  = 0;
          r_pend = 1'b0;
        end
      end
      rd_data_valid = (r_left != 0);
      rd_data_last  = (r_left == 1);
      for (int j = 0; j < WPB; j++) rd_data_in[j*UW +: UW] = seed + 16'(r_idx * WPB + j);
    end
  end

  // User-side monitor
  initial begin
    int widx, bw;
    widx = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn_sync) begin
        widx = 0;
      end else begin
        if (rd_data_ready && !rd_busy) mon_rdy_bad++;
        if (rd_data_ready && user_rd_valid && !(user_rd_ready && (widx % WPB) == WPB - 1)) mon_rdy_bad++;
        if (widx != 0 && !user_rd_valid && rd_busy) mon_gap++;
        if (user_rd_valid && user_rd_ready) begin
          bw = (req_cnt > 0) ? (int'(req_len[(req_cnt - 1) % 32]) + 1) * WPB : 0;
          if (user_rd_data !== seed + 16'(widx)) mon_bad++;
          if (user_rd_last !== (widx == bw - 1)) mon_last_bad++;
          mon_words++;
          if (user_rd_last) begin
            mon_lasts++;
            widx = 0;
          end else begin
            widx++;
          end
        end
      end
    end
  end

  initial begin
    int cnt, w0, g0, l0;
    resetn_sync = 1'b0; ddr_init_done = 1'b0; user_rd_mode = 1'b0; user_rd_req = 1'b0;
    user_rd_addr = '0; user_rd_length = 13'd0; user_base_addr = 32'h0; user_end_addr = 32'h3000;
    wr_burst_done = 1'b0; user_rd_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", user_rd_valid, 1'b0);
    chk("rst_last", user_rd_last, 1'b0);
    chk("rst_data", user_rd_data, 16'h0);
    chk("rst_req_en", rd_req_en, 1'b0);
    chk("rst_addr", rd_addr_out, 32'h0);
    chk("rst_len", rd_burst_len, 8'h0);
    chk("rst_rdy", rd_data_ready, 1'b0);
    chk("rst_busy", rd_busy, 1'b0);
    resetn_sync = 1'b1;
    step();

    // DDR not ready: credit and single-shot pulse must both be held off
    wr_burst_done = 1'b1; step(); wr_burst_done = 1'b0;
    user_rd_mode = 1'b1; user_rd_req = 1'b1; step(); user_rd_req = 1'b0; user_rd_mode = 1'b0;
    repeat (20) step();
    chk("init_low_no_req", req_cnt, 0);
    chk("init_low_avail", dut.avail_cnt_q, 8'd1);
    chk("init_low_busy", rd_busy, 1'b0);
    seed = 16'h0010;
    ddr_init_done = 1'b1;
    cnt = 0;
    while (!rd_req_en && cnt < 50) begin step(); cnt++; end
    chk("init_latency_4_to_8", (cnt >= 4 && cnt <= 8), 1'b1);
    chk("init_addr", rd_addr_out, 32'h0);
    chk("init_len", rd_burst_len, 8'd255);
    wait_lasts(1, 3000, "init_burst_done");
    chk("init_req_cnt", req_cnt, 1);

    // Ring throttle: four credits give four requests, ring wraps at end-BL
    repeat (4) begin wr_burst_done = 1'b1; step(); end
    wr_burst_done = 1'b0;
    wait_lasts(5, 12000, "ring_bursts_done");
    repeat (100) step();
    chk("ring_no_fifth", req_cnt, 5);
    chk("ring_addr1", req_addr[1], 32'h1000);
    chk("ring_addr2", req_addr[2], 32'h2000);
    chk("ring_addr3", req_addr[3], 32'h0000);
    chk("ring_addr4", req_addr[4], 32'h1000);
    for (int i = 1; i <= 4; i++) chk("ring_len", req_len[i], 8'd255);
    chk("ring_avail_zero", dut.avail_cnt_q, 8'd0);
    chk("ring_data_bad", mon_bad, 0);
    chk("ring_last_bad", mon_last_bad, 0);

    // Credit arrives on the same edge a ring request consumes one
    wr_burst_done = 1'b1; step(); wr_burst_done = 1'b0;
    cnt = 0;
    while (!rd_req_en && cnt < 20) begin step(); cnt++; end
    chk("sim_req_seen", rd_req_en, 1'b1);
    wr_burst_done = 1'b1; step(); wr_burst_done = 1'b0;
    chk("sim_avail_kept", dut.avail_cnt_q, 8'd1);
    wait_lasts(7, 6000, "sim_bursts_done");
    chk("sim_req_cnt", req_cnt, 7);
    chk("sim_addr5", req_addr[5], 32'h2000);
    chk("sim_addr6", req_addr[6], 32'h0000);
    chk("sim_avail_zero", dut.avail_cnt_q, 8'd0);

    // Single-shot, 4 beats, no back-pressure
    user_rd_mode = 1'b1; seed = 16'h0000; user_rd_addr = 32'h1000; user_rd_length = 13'd64;
    w0 = mon_words; g0 = mon_gap;
    user_rd_req = 1'b1; step(); user_rd_req = 1'b0;
    wait_lasts(8, 300, "ss_done");
    step();
    chk("ss_addr", req_addr[7], 32'h1000);
    chk("ss_len", req_len[7], 8'd3);
    chk("ss_words", mon_words - w0, 32);
    chk("ss_gaps", mon_gap - g0, 0);
    chk("ss_busy_drop", rd_busy, 1'b0);
    chk("ss_data_bad", mon_bad, 0);
    chk("ss_last_bad", mon_last_bad, 0);

    // Back-pressure on a 2-beat single-shot
    seed = 16'h0200; user_rd_addr = 32'h0400; user_rd_length = 13'd32; w0 = mon_words;
    user_rd_req = 1'b1; step(); user_rd_req = 1'b0;
    cnt = 0;
    while (mon_lasts < 9 && cnt < 300) begin user_rd_ready = ~user_rd_ready; step(); cnt++; end
    user_rd_ready = 1'b1;
    chk("bp_done", mon_lasts, 9);
    chk("bp_len", req_len[8], 8'd1);
    chk("bp_words", mon_words - w0, 16);
    chk("bp_data_bad", mon_bad, 0);
    chk("bp_rdy_bad", mon_rdy_bad, 0);

    // Reset in the middle of a burst
    seed = 16'h0300;
    wr_burst_done = 1'b1; step(); wr_burst_done = 1'b0;
    chk("pre_rst_avail", dut.avail_cnt_q, 8'd1);
    user_rd_addr = 32'h1800; user_rd_length = 13'd64; w0 = mon_words;
    user_rd_req = 1'b1; step(); user_rd_req = 1'b0;
    cnt = 0;
    while ((mon_words - w0) < 5 && cnt < 100) begin step(); cnt++; end
    chk("mid_words_seen", (mon_words - w0) >= 5, 1'b1);
    #2 resetn_sync = 1'b0;
    #1;
    chk("mid_rst_valid", user_rd_valid, 1'b0);
    chk("mid_rst_busy", rd_busy, 1'b0);
    chk("mid_rst_rdy", rd_data_ready, 1'b0);
    chk("mid_rst_avail", dut.avail_cnt_q, 8'd0);
    chk("mid_rst_addr", rd_addr_out, 32'h0);
    chk("mid_rst_data", user_rd_data, 16'h0);
    step(); step();
    resetn_sync = 1'b1;
    repeat (8) step();
    l0 = mon_lasts; seed = 16'h0400; user_rd_addr = 32'h2000; user_rd_length = 13'd16; w0 = mon_words;
    user_rd_req = 1'b1; step(); user_rd_req = 1'b0;
    wait_lasts(l0 + 1, 200, "post_rst_done");
    chk("post_rst_words", mon_words - w0, 8);
    chk("post_rst_addr", req_addr[(req_cnt - 1) % 32], 32'h2000);
    chk("post_rst_len", req_len[(req_cnt - 1) % 32], 8'd0);
    chk("post_rst_data_bad", mon_bad, 0);
    chk("post_rst_last_bad", mon_last_bad, 0);
    chk("final_rdy_bad", mon_rdy_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
